// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// IF_ADEF_CHECK_EN widens the fetch-to-decode bus by one trailing fs_adef bit.
package if_stage_pkg;

`ifdef IF_ADEF_CHECK_EN
    localparam int FS2DS_BUS_LEN = 65;
`else
    localparam int FS2DS_BUS_LEN = 64;
`endif

    localparam int          BR_BUS_LEN       = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_zip_t;

    // Sequential successor; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-to-decode handshake: valid/bus from IF, allowin back from decode.
// Bus width follows IF_ADEF_CHECK_EN through if_stage_pkg.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                     fs2ds_valid;
    logic                     ds_allowin;
    logic [FS2DS_BUS_LEN-1:0] fs2ds_bus;

    modport master (
        output fs2ds_valid,
        output fs2ds_bus,
        input  ds_allowin
    );

    modport slave (
        input  fs2ds_valid,
        input  fs2ds_bus,
        output ds_allowin
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, inst SRAM request, hold buffer, redirect latch.
// IF_ADEF_CHECK_EN enables the misaligned-PC (ADEF) check and the trailing fs_adef bus bit.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    if_stage_if.master            fs2ds,
    input  logic [BR_BUS_LEN-1:0] br_zip,
    input  logic                  wb_ex,
    input  logic                  ertn_flush,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_entry,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_we,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata
);

    br_zip_t     br;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fs_issue;
    logic        flush;
    logic        redirect;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_cancel;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic        redir_pending;
    logic [31:0] redir_target;
    logic [31:0] inst;

    assign br       = br_zip_t'(br_zip);
    assign flush    = wb_ex | ertn_flush;
    assign redirect = flush | br.taken;

    always_comb begin
        nextpc = seq_pc(fs_pc);
        if (wb_ex)
            nextpc = ex_entry;
        else if (ertn_flush)
            nextpc = ertn_entry;
        else if (redir_pending)
            nextpc = redir_target;
        else if (br.taken)
            nextpc = br.target;
    end

    assign to_fs_valid = resetn;
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_ready_go & fs2ds.ds_allowin);
    assign fs_issue    = to_fs_valid & fs_allowin;

    assign inst_sram_we    = '0;
    assign inst_sram_wdata = '0;
    assign inst_sram_addr  = nextpc;

`ifdef IF_ADEF_CHECK_EN
    logic next_adef;
    logic fs_adef;

    assign next_adef    = |nextpc[1:0];
    assign inst_sram_en = fs_issue & ~next_adef;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            fs_adef <= 1'b0;
        else if (fs_issue)
            fs_adef <= next_adef;
    end
`else
    assign inst_sram_en = fs_issue;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_issue) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // A redirect that cannot issue leaves the current IF instruction wrong-path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            fs_cancel <= 1'b0;
        else if (fs_issue)
            fs_cancel <= 1'b0;
        else if (redirect)
            fs_cancel <= 1'b1;
    end

    // nextpc already equals the winning redirect target whenever a latch happens:
    // a flush always wins, and a branch only latches when nothing is pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_pending <= 1'b0;
            redir_target  <= '0;
        end else if (fs_issue) begin
            redir_pending <= 1'b0;
        end else if (flush | (br.taken & ~redir_pending)) begin
            redir_pending <= 1'b1;
            redir_target  <= nextpc;
        end
    end

    // Any issue replaces fs_pc, so buffered data for the old pc is dropped there too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= '0;
        end else if (fs_issue | redirect) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid & ~fs2ds.ds_allowin & ~inst_buf_valid) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

`ifdef IF_ADEF_CHECK_EN
    assign inst            = fs_adef ? '0 : (inst_buf_valid ? inst_buf : inst_sram_rdata);
    assign fs2ds.fs2ds_bus = {fs_pc, inst, fs_adef};
`else
    assign inst            = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs2ds.fs2ds_bus = {fs_pc, inst};
`endif

    assign fs2ds.fs2ds_valid = fs_valid & ~fs_cancel & ~flush;

endmodule
